// File: rtl/ps2_pkg.sv
// Shared scancode constants, event payload and frame FSM state for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_NUMLK  = 8'h77;

  localparam int unsigned PAUSE_SKIP = 7;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  // Keyboard status/response bytes that carry no key information on their own.
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser, clock glitch filter, 11-bit frame deframer and inter-bit timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_err
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt, r_armed, r_strobe, r_strobe_dat;
  logic [FW-1:0] r_filt_cnt;

  frame_state_t  r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_tmo;
  logic          r_byte_valid, r_frame_err;
  logic [7:0]    r_byte_data;

  // Sync flops reset low so a clock held low through reset never arms the strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_s1     <= 1'b0;
      r_clk_s2     <= 1'b0;
      r_dat_s1     <= 1'b0;
      r_dat_s2     <= 1'b0;
      r_filt       <= 1'b1;
      r_filt_cnt   <= '0;
      r_armed      <= 1'b0;
      r_strobe     <= 1'b0;
      r_strobe_dat <= 1'b0;
    end else begin
      r_clk_s1     <= i_ps2_clk;
      r_clk_s2     <= r_clk_s1;
      r_dat_s1     <= i_ps2_data;
      r_dat_s2     <= r_dat_s1;
      r_strobe     <= 1'b0;
      r_strobe_dat <= r_dat_s2;
      if (r_clk_s2) r_armed <= 1'b1;
      if (r_clk_s2 == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt     <= r_clk_s2;
        r_filt_cnt <= '0;
        r_strobe   <= r_filt & r_armed;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  // Frame FSM; the timeout overrides any state other than idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_tmo        <= '0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_state == ST_IDLE || r_strobe) r_tmo <= '0;
      else                                r_tmo <= r_tmo + TW'(1);
      case (r_state)
        ST_IDLE: begin
          if (r_strobe && !r_strobe_dat) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (r_strobe) begin
            r_shift   <= {r_strobe_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (r_strobe) begin
            r_par   <= r_strobe_dat;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (r_strobe) begin
            if (r_strobe_dat && (^{r_shift, r_par})) begin
              r_byte_valid <= 1'b1;
              r_byte_data  <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (r_state != ST_IDLE && !r_strobe && r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        r_state     <= ST_IDLE;
        r_frame_err <= 1'b1;
      end
    end
  end

  assign o_byte_valid = r_byte_valid;
  assign o_byte_data  = r_byte_data;
  assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: prefix folding, modifier/lock tracking and a fall-through event FIFO.
// Define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat makes from the FIFO.
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_ps2_clk,
  input  logic                        i_ps2_data,
  output logic                        o_ev_valid,
  input  logic                        i_ev_ready,
  output logic [7:0]                  o_ev_code,
  output logic                        o_ev_ext,
  output logic                        o_ev_break,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
  output logic                        o_overflow,
  output logic                        o_frame_err,
  output logic                        o_flag_shift,
  output logic                        o_flag_ctrl,
  output logic                        o_flag_caps,
  output logic                        o_flag_numlk
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic       w_byte_valid, w_frame_err;
  logic [7:0] w_byte_data;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_data  (i_ps2_data),
    .o_byte_valid(w_byte_valid),
    .o_byte_data (w_byte_data),
    .o_frame_err (w_frame_err)
  );

  logic       r_ext_pend, r_brk_pend;
  logic [2:0] r_skip_cnt;
  logic       r_lshift, r_rshift, r_lctrl, r_rctrl;
  logic       r_flag_shift, r_flag_ctrl, r_flag_caps, r_flag_numlk;
  logic       r_last_vld;
  logic [8:0] r_last_key;

  ps2_event_t w_ev;
  logic       w_ev_fire, w_new_make, w_push;
  logic [8:0] w_key;
  logic       w_lshift_n, w_rshift_n, w_lctrl_n, w_rctrl_n;

  // Event formation and next modifier-held state.
  always_comb begin
    w_ev.ext   = r_ext_pend;
    w_ev.brk   = r_brk_pend;
    w_ev.code  = w_byte_data;
    w_key      = {r_ext_pend, w_byte_data};
    w_ev_fire  = w_byte_valid && (r_skip_cnt == 3'd0) &&
                 (w_byte_data != SC_E0) && (w_byte_data != SC_F0) && (w_byte_data != SC_E1) &&
                 !(is_status_byte(w_byte_data) && !r_ext_pend && !r_brk_pend);
    w_new_make = !r_brk_pend && (!r_last_vld || (w_key != r_last_key));
`ifdef PS2_TYPEMATIC_FILTER_EN
    w_push     = w_ev_fire && (r_brk_pend || w_new_make);
`else
    w_push     = w_ev_fire;
`endif
    w_lshift_n = r_lshift;
    w_rshift_n = r_rshift;
    w_lctrl_n  = r_lctrl;
    w_rctrl_n  = r_rctrl;
    if (w_ev_fire) begin
      if (w_key == {1'b0, SC_LSHIFT}) w_lshift_n = !r_brk_pend;
      if (w_key == {1'b0, SC_RSHIFT}) w_rshift_n = !r_brk_pend;
      if (w_key == {1'b0, SC_CTRL})   w_lctrl_n  = !r_brk_pend;
      if (w_key == {1'b1, SC_CTRL})   w_rctrl_n  = !r_brk_pend;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ext_pend   <= 1'b0;
      r_brk_pend   <= 1'b0;
      r_skip_cnt   <= '0;
      r_lshift     <= 1'b0;
      r_rshift     <= 1'b0;
      r_lctrl      <= 1'b0;
      r_rctrl      <= 1'b0;
      r_flag_shift <= 1'b0;
      r_flag_ctrl  <= 1'b0;
      r_flag_caps  <= 1'b0;
      r_flag_numlk <= 1'b0;
      r_last_vld   <= 1'b0;
      r_last_key   <= '0;
    end else begin
      if (w_frame_err) begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (w_byte_valid) begin
        if (r_skip_cnt != 3'd0) begin
          r_skip_cnt <= r_skip_cnt - 3'd1;
        end else if (w_byte_data == SC_E1) begin
          r_skip_cnt <= 3'(PAUSE_SKIP);
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end else if (w_byte_data == SC_E0) begin
          r_ext_pend <= 1'b1;
        end else if (w_byte_data == SC_F0) begin
          r_brk_pend <= 1'b1;
        end else if (w_ev_fire) begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      end
      r_lshift     <= w_lshift_n;
      r_rshift     <= w_rshift_n;
      r_lctrl      <= w_lctrl_n;
      r_rctrl      <= w_rctrl_n;
      r_flag_shift <= w_lshift_n | w_rshift_n;
      r_flag_ctrl  <= w_lctrl_n | w_rctrl_n;
      // Last-make tracking: a break of the remembered key re-arms its next make as new.
      if (w_ev_fire) begin
        if (!r_brk_pend) begin
          r_last_key <= w_key;
          r_last_vld <= 1'b1;
        end else if (r_last_vld && w_key == r_last_key) begin
          r_last_vld <= 1'b0;
        end
        if (w_new_make && w_key == {1'b0, SC_CAPS})  r_flag_caps  <= !r_flag_caps;
        if (w_new_make && w_key == {1'b0, SC_NUMLK}) r_flag_numlk <= !r_flag_numlk;
      end
    end
  end

  ps2_event_t        r_mem [FIFO_DEPTH];
  ps2_event_t        r_head, w_head_n;
  logic [AW-1:0]     r_wptr, r_rptr, w_rptr_inc;
  logic [LW-1:0]     r_count, w_count_n;
  logic              r_ev_valid, r_overflow;
  logic              w_full, w_pop, w_wr, w_ovf;

  // Head register is preloaded with the entry that will be at the front next cycle.
  always_comb begin
    w_full     = (r_count == LW'(FIFO_DEPTH));
    w_pop      = r_ev_valid & i_ev_ready;
    w_wr       = w_push & (!w_full | w_pop);
    w_ovf      = w_push & w_full & !w_pop;
    w_rptr_inc = r_rptr + AW'(1);
    w_count_n  = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_n = r_count + LW'(1);
      2'b01:   w_count_n = r_count - LW'(1);
      default: w_count_n = r_count;
    endcase
    w_head_n = r_head;
    if (w_count_n == '0) begin
      w_head_n = '0;
    end else if (r_count == '0 || (w_pop && r_count == LW'(1))) begin
      w_head_n = w_ev;
    end else if (w_pop) begin
      w_head_n = r_mem[w_rptr_inc];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= w_ev;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_ev_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= w_rptr_inc;
      r_count    <= w_count_n;
      r_head     <= w_head_n;
      r_ev_valid <= (w_count_n != '0);
      r_overflow <= r_overflow | w_ovf;
    end
  end

  assign o_ev_valid   = r_ev_valid;
  assign o_ev_code    = r_head.code;
  assign o_ev_ext     = r_head.ext;
  assign o_ev_break   = r_head.brk;
  assign o_fifo_level = r_count;
  assign o_overflow   = r_overflow;
  assign o_frame_err  = w_frame_err;
  assign o_flag_shift = r_flag_shift;
  assign o_flag_ctrl  = r_flag_ctrl;
  assign o_flag_caps  = r_flag_caps;
  assign o_flag_numlk = r_flag_numlk;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed bench for ps2_key_event_rx: bit-banged PS/2 frames with hand-computed expected events.
module tb_ps2_key_event_rx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned FLEN  = 4;
  localparam int unsigned TMO   = 2000;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam int EXP_N1C = 1, EXP_N58 = 1, EXP_TOTAL = 4;
`else
  localparam int EXP_N1C = 3, EXP_N58 = 2, EXP_TOTAL = 7;
`endif

  logic          clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, ev_ready = 1'b0;
  logic          ev_valid, ev_ext, ev_brk, overflow, frame_err;
  logic          flag_shift, flag_ctrl, flag_caps, flag_numlk;
  logic [7:0]    ev_code;
  logic [LW-1:0] fifo_level;

  int n_cmp = 0, n_bad = 0, err_cnt = 0;
  logic [9:0] seen_q[$];

  ps2_key_event_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
    .o_ev_valid(ev_valid), .i_ev_ready(ev_ready), .o_ev_code(ev_code), .o_ev_ext(ev_ext),
    .o_ev_break(ev_brk), .o_fifo_level(fifo_level), .o_overflow(overflow), .o_frame_err(frame_err),
    .o_flag_shift(flag_shift), .o_flag_ctrl(flag_ctrl), .o_flag_caps(flag_caps), .o_flag_numlk(flag_numlk)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err) err_cnt <= err_cnt + 1;
    if (ev_valid && ev_ready) seen_q.push_back({ev_ext, ev_brk, ev_code});
  end

  task automatic frame_bit(input logic v);
    @(posedge clk); #1 ps2_data = v;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (20) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  // Full frame; samples ev_valid just before/after the expected push and can pop in the write cycle.
  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic pulse_ready,
                           output logic v_pre, output logic v_post);
    logic p;
    p = ~(^b) ^ bad_par;
    frame_bit(1'b0);
    for (int i = 0; i < 8; i++) frame_bit(b[i]);
    frame_bit(p);
    @(posedge clk); #1 ps2_data = 1'b1;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (FLEN + 3) @(posedge clk);
    #1 v_pre = ev_valid;
    if (pulse_ready) ev_ready = 1'b1;
    @(posedge clk);
    #1 v_post = ev_valid;
    if (pulse_ready) ev_ready = 1'b0;
    repeat (12) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    logic a, c;
    send_byte(b, 1'b0, 1'b0, a, c);
  endtask

  task automatic pop_ev(output logic v, output logic [9:0] ev);
    v  = ev_valid;
    ev = {ev_ext, ev_brk, ev_code};
    ev_ready = 1'b1;
    @(posedge clk); #1 ev_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; ev_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({ev_valid, ev_code, ev_ext, ev_brk, fifo_level, overflow, frame_err,
         flag_shift, flag_ctrl, flag_caps, flag_numlk} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got valid=%0b code=%h lvl=%0d ovf=%0b, want all 0",
                        ev_valid, ev_code, fifo_level, overflow);
    end
  endtask

  task automatic test_basic();
    logic vpre, vpost, v; logic [9:0] ev;
    send_byte(8'h1C, 1'b0, 1'b0, vpre, vpost);
    n_cmp++; if (vpre !== 1'b0) begin n_bad++; $display("FAIL lat_early: got %0b want 0", vpre); end
    n_cmp++; if (vpost !== 1'b1) begin n_bad++; $display("FAIL lat_rise: got %0b want 1", vpost); end
    send(8'hF0); send(8'h1C);
    n_cmp++; if (fifo_level !== LW'(2)) begin n_bad++; $display("FAIL basic_level: got %0d want 2", fifo_level); end
    pop_ev(v, ev);
    n_cmp++; if ({v, ev} !== {1'b1, 10'h01C}) begin n_bad++; $display("FAIL basic_make: got v=%0b ev=%h want 1/01c", v, ev); end
    pop_ev(v, ev);
    n_cmp++; if ({v, ev} !== {1'b1, 10'h11C}) begin n_bad++; $display("FAIL basic_break: got v=%0b ev=%h want 1/11c", v, ev); end
    n_cmp++; if ({ev_valid, fifo_level, ev_code} !== '0) begin n_bad++; $display("FAIL basic_empty: got v=%0b lvl=%0d code=%h want 0", ev_valid, fifo_level, ev_code); end
    n_cmp++; if ({flag_shift, flag_ctrl, flag_caps, flag_numlk} !== 4'b0) begin n_bad++; $display("FAIL basic_flags: got %b want 0000", {flag_shift, flag_ctrl, flag_caps, flag_numlk}); end
  endtask

  task automatic test_ext_pause();
    logic v; logic [9:0] ev;
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    n_cmp++; if (fifo_level !== LW'(2)) begin n_bad++; $display("FAIL ext_level: got %0d want 2", fifo_level); end
    pop_ev(v, ev);
    n_cmp++; if ({v, ev} !== {1'b1, 10'h275}) begin n_bad++; $display("FAIL ext_make: got v=%0b ev=%h want 1/275", v, ev); end
    pop_ev(v, ev);
    n_cmp++; if ({v, ev} !== {1'b1, 10'h375}) begin n_bad++; $display("FAIL ext_break: got v=%0b ev=%h want 1/375", v, ev); end
    n_cmp++; if ({fifo_level, flag_ctrl, flag_numlk} !== '0) begin n_bad++; $display("FAIL pause_skip: got lvl=%0d ctrl=%0b numlk=%0b want 0", fifo_level, flag_ctrl, flag_numlk); end
  endtask

  task automatic test_errors();
    logic a, c, v; logic [9:0] ev; logic [7:0] b; int e0;
    e0 = err_cnt;
    send_byte(8'h1C, 1'b1, 1'b0, a, c);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL parity_err: got %0d pulses want 1", err_cnt - e0); end
    n_cmp++; if (fifo_level !== LW'(0)) begin n_bad++; $display("FAIL parity_noev: got lvl=%0d want 0", fifo_level); end
    send(8'hF0);
    send_byte(8'h33, 1'b1, 1'b0, a, c);
    send(8'h1C);
    pop_ev(v, ev);
    n_cmp++; if ({v, ev} !== {1'b1, 10'h01C}) begin n_bad++; $display("FAIL err_clears_prefix: got v=%0b ev=%h want 1/01c", v, ev); end
    b = 8'h1C;
    frame_bit(1'b0);
    for (int i = 0; i < 5; i++) frame_bit(b[i]);
    e0 = err_cnt;
    repeat (TMO - 200) @(posedge clk);
    #1;
    n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL timeout_early: got %0d pulses want 0", err_cnt - e0); end
    repeat (300) @(posedge clk);
    #1;
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL timeout_err: got %0d pulses want 1", err_cnt - e0); end
    send(8'h1C);
    pop_ev(v, ev);
    n_cmp++; if ({v, ev} !== {1'b1, 10'h01C}) begin n_bad++; $display("FAIL timeout_recover: got v=%0b ev=%h want 1/01c", v, ev); end
  endtask

  task automatic test_overflow();
    logic a, c, v; logic [9:0] ev;
    logic [7:0] codes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    apply_reset();
    for (int i = 0; i < 5; i++) send(codes[i]);
    n_cmp++; if ({fifo_level, overflow} !== {LW'(DEPTH), 1'b1}) begin n_bad++; $display("FAIL ovf_full: got lvl=%0d ovf=%0b want %0d/1", fifo_level, overflow, DEPTH); end
    for (int i = 0; i < 4; i++) begin
      pop_ev(v, ev);
      n_cmp++; if ({v, ev} !== {1'b1, 2'b00, codes[i]}) begin n_bad++; $display("FAIL ovf_entry%0d: got v=%0b ev=%h want 1/0%h", i, v, ev, codes[i]); end
    end
    n_cmp++; if ({ev_valid, overflow} !== 2'b01) begin n_bad++; $display("FAIL ovf_sticky: got v=%0b ovf=%0b want 0/1", ev_valid, overflow); end
    apply_reset();
    for (int i = 0; i < 4; i++) send(codes[i]);
    send_byte(codes[4], 1'b0, 1'b1, a, c);
    n_cmp++; if ({fifo_level, overflow} !== {LW'(DEPTH), 1'b0}) begin n_bad++; $display("FAIL popwrite_full: got lvl=%0d ovf=%0b want %0d/0", fifo_level, overflow, DEPTH); end
    for (int i = 1; i < 5; i++) begin
      pop_ev(v, ev);
      n_cmp++; if ({v, ev} !== {1'b1, 2'b00, codes[i]}) begin n_bad++; $display("FAIL popwrite_entry%0d: got v=%0b ev=%h want 1/0%h", i, v, ev, codes[i]); end
    end
  endtask

  task automatic test_modifiers();
    int n1c, n58;
    apply_reset();
    seen_q.delete();
    ev_ready = 1'b1;
    send(8'h12);
    n_cmp++; if (flag_shift !== 1'b1) begin n_bad++; $display("FAIL lshift_make: got %0b want 1", flag_shift); end
    send(8'h1C); send(8'h1C); send(8'h1C);
    n_cmp++; if (flag_shift !== 1'b1) begin n_bad++; $display("FAIL lshift_held: got %0b want 1", flag_shift); end
    send(8'hF0); send(8'h12);
    n_cmp++; if (flag_shift !== 1'b0) begin n_bad++; $display("FAIL lshift_break: got %0b want 0", flag_shift); end
    send(8'h58);
    n_cmp++; if (flag_caps !== 1'b1) begin n_bad++; $display("FAIL caps_toggle: got %0b want 1", flag_caps); end
    send(8'h58);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (flag_caps !== 1'b1) begin n_bad++; $display("FAIL caps_repeat: got %0b want 1", flag_caps); end
    n1c = 0; n58 = 0;
    foreach (seen_q[i]) begin
      if (seen_q[i] == 10'h01C) n1c++;
      if (seen_q[i] == 10'h058) n58++;
    end
    n_cmp++; if (n1c !== EXP_N1C) begin n_bad++; $display("FAIL typematic_1c: got %0d want %0d", n1c, EXP_N1C); end
    n_cmp++; if (n58 !== EXP_N58) begin n_bad++; $display("FAIL typematic_58: got %0d want %0d", n58, EXP_N58); end
    n_cmp++; if (seen_q.size() !== EXP_TOTAL) begin n_bad++; $display("FAIL mod_total: got %0d want %0d", seen_q.size(), EXP_TOTAL); end
    send(8'h59);
    n_cmp++; if (flag_shift !== 1'b1) begin n_bad++; $display("FAIL rshift_make: got %0b want 1", flag_shift); end
    send(8'hF0); send(8'h59);
    n_cmp++; if (flag_shift !== 1'b0) begin n_bad++; $display("FAIL rshift_break: got %0b want 0", flag_shift); end
    send(8'hE0); send(8'h14);
    n_cmp++; if (flag_ctrl !== 1'b1) begin n_bad++; $display("FAIL rctrl_make: got %0b want 1", flag_ctrl); end
    send(8'hE0); send(8'hF0); send(8'h14);
    n_cmp++; if (flag_ctrl !== 1'b0) begin n_bad++; $display("FAIL rctrl_break: got %0b want 0", flag_ctrl); end
    send(8'h77);
    n_cmp++; if ({flag_numlk, flag_caps} !== 2'b11) begin n_bad++; $display("FAIL numlk_toggle: got numlk=%0b caps=%0b want 1/1", flag_numlk, flag_caps); end
    ev_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic v; logic [9:0] ev;
    apply_reset();
    send(8'h12); send(8'h1D); send(8'h24);
    n_cmp++; if ({fifo_level, flag_shift} !== {LW'(3), 1'b1}) begin n_bad++; $display("FAIL pre_reset: got lvl=%0d shift=%0b want 3/1", fifo_level, flag_shift); end
    frame_bit(1'b0); frame_bit(1'b0); frame_bit(1'b0); frame_bit(1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({ev_valid, ev_code, ev_ext, ev_brk, fifo_level, overflow, frame_err,
         flag_shift, flag_ctrl, flag_caps, flag_numlk} !== '0) begin
      n_bad++; $display("FAIL midframe_reset: got valid=%0b code=%h lvl=%0d shift=%0b want all 0",
                        ev_valid, ev_code, fifo_level, flag_shift);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    send(8'h1C);
    pop_ev(v, ev);
    n_cmp++; if ({v, ev} !== {1'b1, 10'h01C}) begin n_bad++; $display("FAIL after_reset_frame: got v=%0b ev=%h want 1/01c", v, ev); end
    ps2_data = 1'b0; ps2_clk = 1'b0; rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1 ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (20) @(posedge clk);
    send(8'h1C);
    n_cmp++; if (fifo_level !== LW'(1)) begin n_bad++; $display("FAIL lowclk_level: got %0d want 1", fifo_level); end
    pop_ev(v, ev);
    n_cmp++; if ({v, ev} !== {1'b1, 10'h01C}) begin n_bad++; $display("FAIL lowclk_frame: got v=%0b ev=%h want 1/01c", v, ev); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ext_pause();
    test_errors();
    test_overflow();
    test_modifiers();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_rx.md
# ps2_key_event_rx

Parametrised PS/2 keyboard receiver and decoder, the successor to the current keyboard front end. It filters and deframes the PS/2 serial stream with full error checking and an inter-bit timeout. It folds the E0/F0/E1 prefixes into single key events, tracks modifier and lock state, and buffers events in a configurable FIFO behind a valid/ready handshake. It sits between the board PS/2 pins and the calculator input and text logic.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2
- FILTER_LEN, 4, cycles ps2_clk must be stable before the filtered level changes; ≥1
- TIMEOUT_CYCLES, 50000, maximum cycles between falling edges inside a frame
- clk  in  1  system clock, single clock domain
- rst  in  1  reset, synchronous, active-high
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_data  in  1  raw PS/2 data, asynchronous
- ev_valid  out  1  FIFO non-empty
- ev_ready  in  1  consumer pops the head when ev_valid & ev_ready
- ev_code  out  8  head scancode (prefixes stripped)
- ev_ext  out  1  head was E0-prefixed
- ev_break  out  1  head is a release (F0-prefixed)
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count
- overflow  out  1  sticky; an event was dropped because the FIFO was full
- frame_err  out  1  one-cycle pulse per rejected or timed-out frame
- flag_shift, flag_ctrl, flag_caps, flag_numlk  out  1 each  modifier and lock state

## Operation
- Input path: 2-flop synchroniser on both pins. Filtered clock starts at 1 and changes only after FILTER_LEN identical consecutive synchronised samples. A sample strobe fires on a filtered 1→0 transition.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: strobe with data=0 → DATA; strobe with data=1 is ignored.
  - DATA: 8 bits, LSB first.
  - PARITY: the parity bit is captured here.
  - STOP: stop bit sampled. If data=1 and the 9 bits have odd parity, emit the byte; otherwise pulse frame_err. Return to IDLE in either case.
- Timeout: in any state other than IDLE, TIMEOUT_CYCLES cycles with no strobe → frame_err pulse, return to IDLE, partial byte discarded.
- Any frame_err clears the decoder's pending prefixes.
- Decoder, per byte:
  - E0 sets ext_pend.
  - F0 sets brk_pend.
  - E1 discards itself and the next 7 bytes (Pause).
  - 00, AA, EE, FA, FE, FF with no prefix pending are dropped.
  - Any other byte forms the event {ext_pend, brk_pend, byte} and clears both pend bits.
- Modifiers:
  - Left shift (12) and right shift (59) are held separately; flag_shift is their OR.
  - Left ctrl (14) and right ctrl (E0 14) are held separately; flag_ctrl is their OR.
  - flag_caps toggles on a new make of 58; flag_numlk toggles on a new make of 77.
  - A new make is one whose {ext, code} differs from the last-make register, or follows a break of that key.
  - Modifier and lock keys are enqueued like any other key.
- FIFO: first-word fall-through. ev_code, ev_ext and ev_break are forced to 0 while ev_valid=0.
  - Write when full and no pop → event dropped, overflow set; cleared only by rst.
  - Write while full with a simultaneous pop → both occur, level unchanged, no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset: every output is 0. FSM → IDLE, filter → 1, pend bits, skip counter, held bits and last-make register cleared, FIFO emptied.
  - A reset mid-frame discards the frame.
  - A ps2_clk held low through reset produces no strobe until it has been seen high.

## Timing
- Raw ps2_clk fall → strobe: 2 + FILTER_LEN cycles.
- Stop-bit strobe in cycle N:
  - byte_valid and frame_err are registered in N+1;
  - the decoder writes the FIFO and updates flags in N+1;
  - ev_valid rises in N+2.
- Pop at cycle M (ev_valid & ev_ready) → the next head appears at M+1.
- ev_ready has no combinational path to ev_valid.
- fifo_level is registered and reflects pushes and pops of the previous cycle.

## Configuration
- PS2_TYPEMATIC_FILTER_EN defined: a make that is not a new make (auto-repeat) produces no FIFO write.
- PS2_TYPEMATIC_FILTER_EN undefined: every make is enqueued.
- Lock toggling uses new-make detection in both builds.

## Structure
- Package ps2_pkg holds:
  - scancode constants (E0, F0, E1, LSHIFT 12, RSHIFT 59, CTRL 14, CAPS 58, NUMLK 77);
  - the ps2_event_t packed struct {ext, brk, code[7:0]};
  - the frame FSM state enum.
- Sub-module ps2_frame_rx contains the synchroniser, filter, frame FSM and timeout, with outputs byte_valid, byte_data and frame_err.
- The top level contains the decoder, modifier tracking and FIFO.

## Test plan
- Frame 1C (a), then F0 1C → two events {0,0,1C} and {0,1,1C}; ev_valid rises 2 cycles after the stop strobe; flags unchanged.
- Frame E0 75, then E0 F0 75 → events {1,0,75} and {1,1,75}. Frame E1 14 77 E1 F0 14 F0 77 → no events.
- Frame 1C with bad parity → frame_err pulses once, no event. Stop at the 5th data bit for TIMEOUT_CYCLES → frame_err, then a clean 1C frame is accepted.
- Hold ev_ready=0 and send FIFO_DEPTH+1 makes → fifo_level=FIFO_DEPTH, overflow=1, first FIFO_DEPTH codes intact. Repeat to full with ev_ready=1 on the write cycle → no overflow.
- Send 12, 1C, 1C, 1C, F0 12, then 58, 58 → flag_shift is 1 between 12 and F0 12; flag_caps ends at 1. With the macro, one 1C event and one 58 make are enqueued; without it, three 1C and two 58 makes.
- Assert rst mid-frame (after 4 bits) with 3 entries queued → all outputs 0 next cycle; the following clean frame decodes correctly.
